// File: rtl/uart_bridge_if.sv
// Bus-side strobes and status flags between the CPU memory wrapper (master)
// and the uart_bridge serial responder (slave).
interface uart_bridge_if;
    logic wrn;
    logic rdn;
    logic tbre;
    logic tsre;
    logic data_ready;

    modport master (output wrn, rdn, input tbre, tsre, data_ready);
    modport slave  (input wrn, rdn, output tbre, tsre, data_ready);
endinterface

// File: rtl/uart_bridge.sv
// 8N1 UART responder: latches bus writes into a holding register, serialises on txd,
// deserialises rxd into a buffer read via rdn. Define UART_BRIDGE_RX_FIFO_EN for a 4-deep rx FIFO.
module uart_bridge #(
    parameter int CLK_DIV = 96
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [7:0]   data,
    uart_bridge_if.slave bus,
    output logic         txd,
    input  logic         rxd
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic wrn_q, wrn_d, rdn_q, rdn_d;
    logic rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d, rxd_prev_q, rxd_prev_d;
    logic wr_ev, rd_rel, rx_fall;

    always_comb begin
        wrn_d      = bus.wrn;
        rdn_d      = bus.rdn;
        rxd_s1_d   = rxd;
        rxd_s2_d   = rxd_s1_q;
        rxd_prev_d = rxd_s2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrn_q      <= 1'b1;
            rdn_q      <= 1'b1;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            wrn_q      <= wrn_d;
            rdn_q      <= rdn_d;
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    assign wr_ev   = wrn_q & ~bus.wrn;
    assign rd_rel  = ~rdn_q & bus.rdn;
    assign rx_fall = rxd_prev_q & ~rxd_s2_q;

    // ---------------- transmit ----------------
    state_t        tx_st_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic [7:0]    tx_sh_q, hold_q;
    logic          tbre_q, tsre_q, txd_q;
    logic          tx_end;

    assign tx_end = (tx_cnt_q == LAST);

    // tbre_q doubles as "holding register empty", so a write and a reload never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q  <= S_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            tx_sh_q  <= '0;
            hold_q   <= '0;
            tbre_q   <= 1'b1;
            tsre_q   <= 1'b1;
            txd_q    <= 1'b1;
        end else begin
            if (wr_ev && tbre_q) begin
                hold_q <= data;
                tbre_q <= 1'b0;
            end
            tx_cnt_q <= (tx_st_q == S_IDLE || tx_end) ? '0 : tx_cnt_q + CW'(1);
            case (tx_st_q)
                S_IDLE: if (!tbre_q) begin
                    tx_sh_q <= hold_q;
                    tbre_q  <= 1'b1;
                    tsre_q  <= 1'b0;
                    txd_q   <= 1'b0;
                    tx_st_q <= S_START;
                end
                S_START: if (tx_end) begin
                    txd_q    <= tx_sh_q[0];
                    tx_idx_q <= '0;
                    tx_st_q  <= S_DATA;
                end
                S_DATA: if (tx_end) begin
                    if (tx_idx_q == 3'd7) begin
                        txd_q   <= 1'b1;
                        tx_st_q <= S_STOP;
                    end else begin
                        txd_q    <= tx_sh_q[1];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_idx_q <= tx_idx_q + 3'd1;
                    end
                end
                S_STOP: if (tx_end) begin
                    if (!tbre_q) begin
                        tx_sh_q <= hold_q;
                        tbre_q  <= 1'b1;
                        txd_q   <= 1'b0;
                        tx_st_q <= S_START;
                    end else begin
                        tsre_q  <= 1'b1;
                        tx_st_q <= S_IDLE;
                    end
                end
                default: tx_st_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive ----------------
    state_t        rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_sh_q;
    logic          rx_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_idx_q  <= '0;
            rx_sh_q   <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_cnt_q  <= (rx_st_q == S_IDLE) ? '0 : rx_cnt_q + CW'(1);
            case (rx_st_q)
                S_IDLE: if (rx_fall) rx_st_q <= S_START;
                S_START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    rx_idx_q <= '0;
                    rx_st_q  <= rxd_s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt_q == LAST) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rxd_s2_q, rx_sh_q[7:1]};
                    rx_idx_q <= rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) rx_st_q <= S_STOP;
                end
                S_STOP: if (rx_cnt_q == LAST) begin
                    rx_done_q <= rxd_s2_q;
                    rx_st_q   <= S_IDLE;
                end
                default: rx_st_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive buffer ----------------
    logic [7:0] rd_byte;
    logic       dr_q, dr_d;

`ifdef UART_BRIDGE_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [1:0] wp_q, wp_d, rp_q, rp_d;
    logic [2:0] cnt_q, cnt_d;
    logic       push, pop;

    // a pop frees the slot the same cycle, so a full FIFO still accepts a byte alongside a pop
    always_comb begin
        pop    = rd_rel && (cnt_q != 3'd0);
        push   = rx_done_q && ((cnt_q != 3'd4) || pop);
        fifo_d = fifo_q;
        if (push) fifo_d[wp_q] = rx_sh_q;
        wp_d   = wp_q + 2'(push);
        rp_d   = rp_q + 2'(pop);
        cnt_d  = cnt_q + 3'(push) - 3'(pop);
        dr_d   = (cnt_d != 3'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            dr_q  <= 1'b0;
        end else begin
            fifo_q <= fifo_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            dr_q   <= dr_d;
        end
    end

    assign rd_byte = fifo_q[rp_q];
`else
    logic [7:0] rbuf_q, rbuf_d;

    // delivery outranks a simultaneous read-release so the fresh byte is never lost
    always_comb begin
        rbuf_d = rbuf_q;
        dr_d   = dr_q;
        if (rx_done_q) begin
            rbuf_d = rx_sh_q;
            dr_d   = 1'b1;
        end else if (rd_rel) begin
            dr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbuf_q <= '0;
            dr_q   <= 1'b0;
        end else begin
            rbuf_q <= rbuf_d;
            dr_q   <= dr_d;
        end
    end

    assign rd_byte = rbuf_q;
`endif

    assign data           = bus.rdn ? 8'bz : rd_byte;
    assign bus.tbre       = tbre_q;
    assign bus.tsre       = tsre_q;
    assign bus.data_ready = dr_q;
    assign txd            = txd_q;
endmodule

// File: tb/tb_uart_bridge.sv
// Bench for uart_bridge: table vectors for tx/rx frames, hand sequences for timing corners,
// and random traffic checked against a frame-level model (rx buffer modelled as a bounded queue).
module tb_uart_bridge;
    localparam int DIV = 96;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] data_bus;
    wire        txd;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    uart_bridge_if bus();

    assign data_bus = drv_en ? drv_val : 8'bz;

    uart_bridge #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst_n),
        .data(data_bus),
        .bus (bus),
        .txd (txd),
        .rxd (rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- txd frame monitor ----------------
    typedef struct {
        logic [9:0] bits;
        int         start;
    } frame_t;
    frame_t tx_q[$];

    initial begin : mon
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                f.start = cyc;
                f.bits  = '0;
                repeat (DIV / 2) @(negedge clk);
                f.bits[0] = txd;
                for (int k = 1; k < 10; k++) begin
                    repeat (DIV) @(negedge clk);
                    f.bits[k] = txd;
                end
                tx_q.push_back(f);
            end
        end
    end

    // ---------------- rx reference model: delivered-but-unread bytes ----------------
    logic [7:0] mq[$];

    task automatic model_deliver(input logic [7:0] d);
`ifdef UART_BRIDGE_RX_FIFO_EN
        if (mq.size() < 4) mq.push_back(d);
`else
        mq.delete();
        mq.push_back(d);
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input string name);
        int t = 0;
        while (!(bus.tbre && bus.tsre) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_idle"}, {31'd0, bus.tbre & bus.tsre}, 32'd1);
    endtask

    task automatic wait_frame(input string name, output frame_t f);
        int t = 0;
        while (tx_q.size() == 0 && t < 1200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_frame_seen"}, {31'd0, tx_q.size() != 0}, 32'd1);
        if (tx_q.size() != 0) f = tx_q.pop_front();
        else f = '{bits: 10'h0, start: 0};
    endtask

    task automatic do_write(input logic [7:0] d, output int wc);
        @(negedge clk);
        drv_en  = 1'b1;
        drv_val = d;
        bus.wrn = 1'b0;
        wc      = cyc;
        @(negedge clk);
        bus.wrn = 1'b1;
        drv_en  = 1'b0;
    endtask

    task automatic do_read(output logic [7:0] v);
        @(negedge clk);
        bus.rdn = 1'b0;
        #1 v = data_bus;
        @(negedge clk);
        bus.rdn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;   // bit i = txd level in bit slot i (start, d0..d7, stop)
    } tx_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       glitch;
        logic       exp_rdy;
        logic       chk_data;
        logic [7:0] exp_data;
    } rx_vec_t;

`ifdef UART_BRIDGE_RX_FIFO_EN
    localparam logic STALE = 1'b0;
`else
    localparam logic STALE = 1'b1;
`endif

    tx_vec_t tx_tab[6];
    rx_vec_t rx_tab[6];

    initial begin : main
        int         wc, wc2, lat;
        frame_t     f, f2;
        logic [7:0] v, d;
        int         n;

        tx_tab[0] = '{8'h55, 10'h2AA};
        tx_tab[1] = '{8'hA5, 10'h34A};
        tx_tab[2] = '{8'h3C, 10'h278};
        tx_tab[3] = '{8'h00, 10'h200};
        tx_tab[4] = '{8'hFF, 10'h3FE};
        tx_tab[5] = '{8'h81, 10'h302};

        rx_tab[0] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1,  8'hC3};
        rx_tab[1] = '{8'hA7, 1'b0, 1'b0, 1'b0, STALE, 8'hC3};
        rx_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b0, STALE, 8'hC3};
        rx_tab[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1,  8'h00};
        rx_tab[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1,  8'hFF};
        rx_tab[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1,  8'h81};

        bus.wrn = 1'b1;
        bus.rdn = 1'b1;

        // reset state, then 2000 quiet cycles
        repeat (4) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            chk("idle_txd", {31'd0, txd}, 32'd1);
            chk("idle_tbre", {31'd0, bus.tbre}, 32'd1);
            chk("idle_tsre", {31'd0, bus.tsre}, 32'd1);
            chk("idle_data_ready", {31'd0, bus.data_ready}, 32'd0);
        end

        // transmit table
        for (int i = 0; i < 6; i++) begin
            wait_idle("tx_tab");
            do_write(tx_tab[i].d, wc);
            chk("tx_tbre_after_write", {31'd0, bus.tbre}, 32'd0);
            @(negedge clk);
            chk("tx_tbre_after_load", {31'd0, bus.tbre}, 32'd1);
            chk("tx_tsre_busy", {31'd0, bus.tsre}, 32'd0);
            chk("tx_start_bit", {31'd0, txd}, 32'd0);
            wait_frame("tx_tab", f);
            chk("tx_frame_bits", {22'd0, f.bits}, {22'd0, tx_tab[i].frame});
            lat = 0;
            while (!bus.tsre && lat < 2000) begin
                @(negedge clk);
                lat++;
            end
            lat = cyc - wc;
            chk("tx_tsre_latency", (lat >= 960 && lat <= 964) ? 32'd962 : lat, 32'd962);
        end

        // back-to-back frames, then a write while the holding register is full
        wait_idle("b2b");
        do_write(8'hA5, wc);
        @(negedge clk);
        do_write(8'h3C, wc2);
        repeat (3) @(negedge clk);
        chk("b2b_tbre_full", {31'd0, bus.tbre}, 32'd0);
        do_write(8'hEE, wc2);
        wait_frame("b2b_1", f);
        wait_frame("b2b_2", f2);
        chk("b2b_frame1", {22'd0, f.bits}, {22'd0, 1'b1, 8'hA5, 1'b0});
        chk("b2b_frame2", {22'd0, f2.bits}, {22'd0, 1'b1, 8'h3C, 1'b0});
        chk("b2b_no_gap", f2.start - f.start, 10 * DIV);
        wait_idle("b2b_end");
        repeat (1200) @(negedge clk);
        chk("b2b_dropped_write", tx_q.size(), 32'd0);

        // reset mid-frame
        wait_idle("rst_mid");
        do_write(8'h0F, wc);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", {31'd0, txd}, 32'd1);
        chk("rst_mid_tbre", {31'd0, bus.tbre}, 32'd1);
        chk("rst_mid_tsre", {31'd0, bus.tsre}, 32'd1);
        chk("rst_mid_data_ready", {31'd0, bus.data_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        tx_q.delete();
        chk("rst_mid_no_resume", {30'd0, txd, bus.tsre}, 32'd3);

        // rx latency from start edge to data_ready
        fork
            send_rx(8'h5A, 1'b1);
            begin
                repeat (905) @(negedge clk);
                chk("rx_lat_early", {31'd0, bus.data_ready}, 32'd0);
                repeat (20) @(negedge clk);
                chk("rx_lat_late", {31'd0, bus.data_ready}, 32'd1);
            end
        join
        do_read(v);
        chk("rx_lat_data", {24'd0, v}, 32'h5A);
        chk("rx_lat_cleared", {31'd0, bus.data_ready}, 32'd0);

        // receive table
        for (int i = 0; i < 6; i++) begin
            if (rx_tab[i].glitch) begin
                @(negedge clk);
                rxd = 1'b0;
                repeat (20) @(negedge clk);
                rxd = 1'b1;
                repeat (11 * DIV) @(negedge clk);
            end else begin
                send_rx(rx_tab[i].d, rx_tab[i].stop);
                repeat (DIV) @(negedge clk);
            end
            chk("rx_ready", {31'd0, bus.data_ready}, {31'd0, rx_tab[i].exp_rdy});
            do_read(v);
            if (rx_tab[i].chk_data) chk("rx_data", {24'd0, v}, {24'd0, rx_tab[i].exp_data});
            chk("rx_ready_after_read", {31'd0, bus.data_ready}, 32'd0);
            if (i == 0) begin
                @(negedge clk);
                drv_en  = 1'b1;
                drv_val = 8'h3C;
                #1 chk("bus_released", {24'd0, data_bus}, 32'h3C);
                @(negedge clk);
                drv_en = 1'b0;
            end
        end

        // five unread bytes, then five reads
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), 1'b1);
            repeat (10) @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
`ifdef UART_BRIDGE_RX_FIFO_EN
            chk("burst_ready", {31'd0, bus.data_ready}, {31'd0, i < 4});
            do_read(v);
            if (i < 4) chk("burst_data", {24'd0, v}, i + 1);
`else
            chk("burst_ready", {31'd0, bus.data_ready}, {31'd0, i == 0});
            do_read(v);
            if (i == 0) chk("burst_data", {24'd0, v}, 32'h05);
`endif
        end
        chk("burst_empty", {31'd0, bus.data_ready}, 32'd0);

        // random transmit traffic
        mq.delete();
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!bus.tbre && n < 2000) begin
                @(negedge clk);
                n++;
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
            d = 8'($urandom);
            mq.push_back(d);
            do_write(d, wc);
        end
        wait_idle("rand_tx");
        repeat (100) @(negedge clk);
        chk("rand_tx_count", tx_q.size(), mq.size());
        while (mq.size() != 0 && tx_q.size() != 0) begin
            f = tx_q.pop_front();
            d = mq.pop_front();
            chk("rand_tx_frame", {22'd0, f.bits}, {22'd0, 1'b1, d, 1'b0});
        end
        mq.delete();

        // random receive traffic against the buffer model
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                send_rx(d, 1'b1);
                model_deliver(d);
                repeat ($urandom_range(2, 30)) @(negedge clk);
            end
            for (int i = 0; i <= n; i++) begin
                chk("rand_rx_ready", {31'd0, bus.data_ready}, {31'd0, mq.size() != 0});
                do_read(v);
                if (mq.size() != 0) chk("rand_rx_data", {24'd0, v}, {24'd0, mq.pop_front()});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_bridge.md
# uart_bridge

Serial-side responder for the CPU's UART port. The memory wrapper drives the shared data bus `ram_data[7:0]` and the `rdn`/`wrn` strobes, and reads back `tbre`/`tsre`/`data_ready`. This block owns the other end of that interface. It latches bytes written with `wrn`, serialises them onto `txd` as 8N1, deserialises `rxd` into a receive buffer, and drives the buffered byte onto the bus while `rdn` is low.

## Interface
- `CLK_DIV`, 96: clk cycles per bit (11.0592 MHz / 115200).
- `clk  in  1`: system clock, all logic on rising edge.
- `rst  in  1`: asynchronous reset, active-low.
- `data  inout  8`: shared bus, low byte of `ram_data`; driven only while `rdn`=0.
- `wrn  in  1`: write strobe, active-low, synchronous to `clk`.
- `rdn  in  1`: read strobe, active-low, synchronous to `clk`.
- `tbre  out  1`: transmit holding register empty.
- `tsre  out  1`: transmit shift register empty (line idle).
- `data_ready  out  1`: received byte available.
- `txd  out  1`: serial out, idle high.
- `rxd  in  1`: serial in, asynchronous, 2-FF synchronised.

## Operation
- Reset values: `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, all counters 0, `data` hi-Z.
- Strobe edges are detected from a registered previous value.
  - Write event: `wrn` sampled 0 after 1. `data` is captured that cycle.
  - Read-release event: `rdn` sampled 1 after 0.
- Write with `tbre`=1: load the holding register and set `tbre`=0.
- Write with `tbre`=0: drop the byte; holding register unchanged.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: if the holding register is full, move it to the shifter, set `tbre`=1 and `tsre`=0, and go to START.
  - START: drive `txd`=0.
  - DATA: 8 bits, LSB first, with a 3-bit index.
  - STOP: drive `txd`=1.
  - Each state lasts `CLK_DIV` cycles, counted by a baud counter.
  - At the end of STOP, go to IDLE and set `tsre`=1, unless the holding register is full. In that case reload immediately and go to START, keeping `tsre`=0.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: a synchronised `rxd` falling edge goes to START.
  - START: re-check at `CLK_DIV/2`. If `rxd`=1, treat it as a glitch and return to IDLE.
  - DATA: sample every `CLK_DIV` cycles, 8 bits, LSB first.
  - STOP: sample at mid-bit. If 1, deliver the byte. If 0, it is a framing error: discard the byte and return to IDLE.
- Delivery (base build): write the rx buffer and set `data_ready`=1. An unread byte is overwritten, newest wins.
- Read: `data` = `rdn` ? 8'bz : rx buffer, combinational.
  - The read-release event clears `data_ready`.
  - A read with `data_ready`=0 returns the stale buffer and changes nothing.
- Simultaneous delivery and read-release in the same cycle: delivery wins, and `data_ready` stays 1 with the new byte.
- Reset mid-frame: both FSMs return to IDLE and all outputs return to their reset values immediately. Partial frames are lost.

## Timing
- Write event in cycle N with TX idle:
  - `tbre` is 0 after edge N+1 and back to 1 after edge N+2.
  - `tsre` is 0 after edge N+2.
  - `txd` falls after edge N+2.
- One frame is exactly 10·`CLK_DIV` cycles of `txd`. `tsre` rises on the cycle after the stop bit's last cycle.
- Back-to-back frames with the holding register preloaded have no idle gap between stop and start.
- RX latency: `data_ready` rises 1 cycle after the stop-bit mid-sample. That is about 9.5·`CLK_DIV` + 3 cycles after the `rxd` start edge, including the synchroniser.
- `data` drive tracks `rdn` combinationally, with no clock latency.

## Configuration
- `UART_BRIDGE_RX_FIFO_EN`: when defined, the single rx buffer is replaced by a 4-entry FIFO with 2-bit pointers and wrap-around.
  - `data_ready` means the FIFO is not empty.
  - `data` shows the head entry.
  - A read-release event pops one entry.
  - Delivery while the FIFO is full drops the new byte.
  - Delivery and pop in the same cycle on a full FIFO: both happen and the count stays 4.
- When undefined, the block uses the single buffer with overwrite as described under Operation.

## Test plan
- Reset release, no stimulus: `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `data`=Z for 2000 cycles.
- Write 0x55: `txd` shows 0,1,0,1,0,1,0,1,0,1 for 96 cycles each, and `tsre` returns to 1 at cycle 962 ±2.
- Two writes 0xA5 then 0x3C, 2 cycles apart: the frames are contiguous with no gap, and a third write issued while `tbre`=0 is dropped.
- Drive an `rxd` frame 0xC3 at `CLK_DIV`=96: `data_ready`=1. Pulse `rdn` low: `data`=0xC3. On `rdn` release, `data_ready`=0.
- Drive an `rxd` frame with stop bit 0, and separately a 20-cycle low glitch: `data_ready` stays 0 in both cases.
- With `UART_BRIDGE_RX_FIFO_EN`: receive 0x01..0x05 unread, then do 5 reads. The reads return 0x01..0x04, and `data_ready`=0 after the fourth read.
